// File: rtl/ssd_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter and its picker.
// The optional urgent-requester feature is selected by SSD_ARB_PREEMPT_EN (see top).
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } ssd_state_e;

    localparam int SSD_DIGITS = 4;
    localparam int SSD_DATA_W = 16;
    localparam int SSD_DP_W   = 4;

    // Counter/index width for a range of n values, never narrower than one bit.
    function automatic int ssd_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssd_display_arbiter_if.sv
// Requester-side bus of the display arbiter: request/data inputs and the granted display outputs.
// master = requesters plus SSD driver side, slave = arbiter.
interface ssd_display_arbiter_if
    import ssd_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = ssd_cnt_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [SSD_DATA_W*NUM_REQ-1:0] req_data;
    logic [SSD_DP_W*NUM_REQ-1:0]   req_dp;
    logic [NUM_REQ-1:0]            grant;
    logic [IDX_W-1:0]              owner;
    logic [SSD_DATA_W-1:0]         data_out;
    logic [SSD_DP_W-1:0]           dp_out;
    logic                          disp_en;

    modport master (
        output req, req_data, req_dp,
        input  grant, owner, data_out, dp_out, disp_en
    );

    modport slave (
        input  req, req_data, req_dp,
        output grant, owner, data_out, dp_out, disp_en
    );

endinterface

// File: rtl/ssd_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from last+1 upward, wrapping,
// so the previous winner is considered last. Generic enough for other shared-resource arbiters.
module ssd_rr_pick
    import ssd_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = ssd_cnt_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    // Walk the candidates in priority order; the first hit locks the result.
    always_comb begin : pick_search
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             hit;
        cand     = 0;
        cand_idx = '0;
        hit      = 1'b0;
        valid    = 1'b0;
        onehot   = '0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand             = (int'(last) + k) % NUM_REQ;
            cand_idx         = IDX_W'(cand);
            hit              = req[cand_idx] & ~valid;
            onehot[cand_idx] = onehot[cand_idx] | hit;
            idx              = hit ? cand_idx : idx;
            valid            = valid | hit;
        end
    end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin owner of one multiplexed 4-digit SSD with minimum hold time and blank handover gap.
// Define SSD_ARB_PREEMPT_EN to make requester 0 urgent (preempts any hold, always wins).
module ssd_display_arbiter
    import ssd_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLANK_CYCLES = 2,
    parameter int CNT_W        = 26
) (
    input logic                  clk,
    input logic                  rst,
    ssd_display_arbiter_if.slave bus
);

    localparam int IDX_W = ssd_cnt_w(NUM_REQ);
    localparam int BLK_W = ssd_cnt_w(BLANK_CYCLES);

    ssd_state_e              state_r;
    logic [NUM_REQ-1:0]      grant_r;
    logic [IDX_W-1:0]        owner_r;
    logic [SSD_DATA_W-1:0]   data_r;
    logic [SSD_DP_W-1:0]     dp_r;
    logic                    en_r;
    logic [CNT_W-1:0]        hold_cnt_r;
    logic [BLK_W-1:0]        blank_cnt_r;

    logic                    pick_valid_s;
    logic [NUM_REQ-1:0]      pick_onehot_s;
    logic [IDX_W-1:0]        pick_idx_s;
    logic                    win_valid_s;
    logic [NUM_REQ-1:0]      win_onehot_s;
    logic [IDX_W-1:0]        win_idx_s;
    logic                    preempt_s;
    logic [SSD_DATA_W-1:0]   win_data_s;
    logic [SSD_DP_W-1:0]     win_dp_s;
    logic [SSD_DATA_W-1:0]   own_data_s;
    logic [SSD_DP_W-1:0]     own_dp_s;
    logic                    hold_done_s;
    logic                    others_s;
    logic                    release_s;
    logic                    gap_last_s;

    ssd_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (bus.req),
        .last   (owner_r),
        .valid  (pick_valid_s),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s)
    );

    // Winner selection: plain round robin, optionally overridden by the urgent requester 0.
    always_comb begin
        win_valid_s  = pick_valid_s;
        win_onehot_s = pick_onehot_s;
        win_idx_s    = pick_idx_s;
        preempt_s    = 1'b0;
`ifdef SSD_ARB_PREEMPT_EN
        if (bus.req[0]) begin
            win_valid_s  = 1'b1;
            win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1};
            win_idx_s    = '0;
        end else begin
            win_valid_s  = pick_valid_s;
        end
        preempt_s = bus.req[0] & (owner_r != '0);
`endif
    end

    assign win_data_s  = bus.req_data[int'(win_idx_s)*SSD_DATA_W +: SSD_DATA_W];
    assign win_dp_s    = bus.req_dp[int'(win_idx_s)*SSD_DP_W +: SSD_DP_W];
    assign own_data_s  = bus.req_data[int'(owner_r)*SSD_DATA_W +: SSD_DATA_W];
    assign own_dp_s    = bus.req_dp[int'(owner_r)*SSD_DP_W +: SSD_DP_W];

    // grant_r is one-hot on the owner while in OWN, so masking with it isolates Req[Owner].
    assign hold_done_s = (hold_cnt_r == CNT_W'(HOLD_CYCLES - 1));
    assign others_s    = |(bus.req & ~grant_r);
    assign release_s   = ~(|(bus.req & grant_r)) | (hold_done_s & others_s) | preempt_s;
    assign gap_last_s  = (blank_cnt_r == BLK_W'(BLANK_CYCLES - 1));

    // Arbitration FSM with hold/blank counters and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            owner_r     <= IDX_W'(NUM_REQ - 1);
            data_r      <= '0;
            dp_r        <= '0;
            en_r        <= 1'b0;
            hold_cnt_r  <= '0;
            blank_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        state_r    <= ST_OWN;
                        grant_r    <= win_onehot_s;
                        owner_r    <= win_idx_s;
                        data_r     <= win_data_s;
                        dp_r       <= win_dp_s;
                        en_r       <= 1'b1;
                        hold_cnt_r <= '0;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (release_s) begin
                        state_r     <= ST_GAP;
                        grant_r     <= '0;
                        data_r      <= '0;
                        dp_r        <= '0;
                        en_r        <= 1'b0;
                        blank_cnt_r <= '0;
                    end else begin
                        data_r      <= own_data_s;
                        dp_r        <= own_dp_s;
                        hold_cnt_r  <= hold_done_s ? hold_cnt_r : hold_cnt_r + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_last_s) begin
                        if (win_valid_s) begin
                            state_r    <= ST_OWN;
                            grant_r    <= win_onehot_s;
                            owner_r    <= win_idx_s;
                            data_r     <= win_data_s;
                            dp_r       <= win_dp_s;
                            en_r       <= 1'b1;
                            hold_cnt_r <= '0;
                        end else begin
                            state_r    <= ST_IDLE;
                        end
                    end else begin
                        blank_cnt_r <= blank_cnt_r + BLK_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    data_r  <= '0;
                    dp_r    <= '0;
                    en_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_r;
    assign bus.owner    = owner_r;
    assign bus.data_out = data_r;
    assign bus.dp_out   = dp_r;
    assign bus.disp_en  = en_r;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Self-checking bench for ssd_display_arbiter (NUM_REQ=4, HOLD_CYCLES=8, BLANK_CYCLES=2).
// Directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_ssd_display_arbiter;

    localparam int N     = 4;
    localparam int HOLD  = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_v;
    logic [63:0] data_v;
    logic [15:0] dp_v;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 idle, 1 owning, 2 blanking
    int          m_phase, m_owner, m_held, m_gap_left;
    logic [3:0]  m_grant;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic        m_en;

    ssd_display_arbiter_if #(.NUM_REQ(N)) ifc ();

    assign ifc.req      = req_v;
    assign ifc.req_data = data_v;
    assign ifc.req_dp   = dp_v;

    ssd_display_arbiter #(
        .NUM_REQ      (N),
        .HOLD_CYCLES  (HOLD),
        .BLANK_CYCLES (BLANK),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [3:0] r, input int last);
`ifdef SSD_ARB_PREEMPT_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_to_idx(input logic [3:0] g);
        for (int i = 0; i < N; i++) if (g == (4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = N - 1; m_held = 0; m_gap_left = 0;
        m_grant = 4'b0; m_data = 16'h0; m_dp = 4'h0; m_en = 1'b0;
    endtask

    task automatic model_enter(input int w);
        m_phase = 1; m_owner = w; m_held = 1;
        m_grant = 4'b0001 << w; m_en = 1'b1;
        m_data = data_v[16*w +: 16]; m_dp = dp_v[4*w +: 4];
    endtask

    task automatic model_step();
        int  w;
        bit  others, urgent, leave;
        if (m_phase == 1) begin
            others = |(req_v & ~(4'b0001 << m_owner));
            urgent = 1'b0;
`ifdef SSD_ARB_PREEMPT_EN
            urgent = req_v[0] && (m_owner != 0);
`endif
            leave = !req_v[m_owner] || (m_held >= HOLD && others) || urgent;
            if (leave) begin
                m_phase = 2; m_gap_left = BLANK;
                m_grant = 4'b0; m_en = 1'b0; m_data = 16'h0; m_dp = 4'h0;
            end else begin
                m_held++;
                m_data = data_v[16*m_owner +: 16]; m_dp = dp_v[4*m_owner +: 4];
            end
        end else if (m_phase == 2) begin
            if (m_gap_left == 1) begin
                w = rr_pick(req_v, m_owner);
                if (w >= 0) model_enter(w);
                else m_phase = 0;
            end else begin
                m_gap_left--;
            end
        end else begin
            w = rr_pick(req_v, m_owner);
            if (w >= 0) model_enter(w);
        end
    endtask

    // Advance one clock; leaves the bench at posedge+1 with DUT and model updated.
    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_v = 4'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req_v  = 4'b0;
        data_v = {$urandom, $urandom};
        dp_v   = 16'($urandom);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ifc.grant !== 4'b0 || ifc.disp_en !== 1'b0 || ifc.data_out !== 16'h0 ||
            ifc.dp_out !== 4'h0 || ifc.owner !== 2'd3) begin
            n_fail++;
            $display("FAIL reset: grant=%b en=%b data=%h dp=%h owner=%0d, required 0000 0 0000 0 3",
                     ifc.grant, ifc.disp_en, ifc.data_out, ifc.dp_out, ifc.owner);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_pick();
        int bad;
        data_v = 64'h4444_3333_2222_1111;
        req_v  = 4'b0110;
        step();
        n_tests++;
        if (ifc.grant !== 4'b0010 || ifc.data_out !== 16'h2222 || ifc.owner !== 2'd1) begin
            n_fail++;
            $display("FAIL idle_pick: grant=%b data=%h owner=%0d, required 0010 2222 1",
                     ifc.grant, ifc.data_out, ifc.owner);
        end
        req_v = 4'b0010;
        bad   = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ifc.grant !== 4'b0010 || ifc.disp_en !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sole_owner_stays: %0d cycles lost the grant, required 0", bad);
        end
    endtask

    task automatic test_handover();
        int         own_cnt, gap_cnt, got, prev_idx, gi;
        int         seq[3];
        logic [3:0] prev;
        do_reset();
        req_v   = 4'b0110;
        own_cnt = 0;
        gap_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ifc.grant === 4'b0010 && ifc.disp_en === 1'b1) own_cnt++;
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (ifc.grant === 4'b0000 && ifc.disp_en === 1'b0) gap_cnt++;
        end
        step();
        n_tests++;
        if (own_cnt != 8 || gap_cnt != 2 || ifc.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL handover: own=%0d gap=%0d grant=%b, required 8 2 0100",
                     own_cnt, gap_cnt, ifc.grant);
        end
        req_v = 4'b1111;
        prev  = ifc.grant;
        got   = 0;
        for (int c = 0; c < 100 && got < 3; c++) begin
            step();
            if (ifc.grant !== 4'b0 && ifc.grant !== prev) begin
                seq[got] = onehot_to_idx(ifc.grant);
                got++;
            end
            if (ifc.grant !== 4'b0) prev = ifc.grant;
        end
        n_tests++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL rr_order_timeout: saw %0d handovers, required 3", got);
        end else begin
            prev_idx = 2;
            for (int i = 0; i < 3; i++) begin
                gi = (prev_idx + 1) % N;
                n_tests++;
                if (seq[i] != gi) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: owner=%0d, required %0d", i, seq[i], gi);
                end
                prev_idx = gi;
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        req_v = 4'b0100;
        repeat (3) step();
        req_v = 4'b0000;
        step();
        n_tests++;
        if (ifc.disp_en !== 1'b0 || ifc.grant !== 4'b0) begin
            n_fail++;
            $display("FAIL drop_gap: en=%b grant=%b, required 0 0000", ifc.disp_en, ifc.grant);
        end
        repeat (4) step();
        n_tests++;
        if (ifc.grant !== 4'b0 || ifc.disp_en !== 1'b0 || ifc.owner !== 2'd2) begin
            n_fail++;
            $display("FAIL drop_idle: grant=%b en=%b owner=%0d, required 0000 0 2",
                     ifc.grant, ifc.disp_en, ifc.owner);
        end
    endtask

    task automatic test_live_data();
        data_v = 64'h0;
        data_v[15:0] = 16'h1234;
        dp_v   = 16'h0005;
        req_v  = 4'b0001;
        step();
        n_tests++;
        if (ifc.grant !== 4'b0001 || ifc.data_out !== 16'h1234 || ifc.dp_out !== 4'h5) begin
            n_fail++;
            $display("FAIL live_first: grant=%b data=%h dp=%h, required 0001 1234 5",
                     ifc.grant, ifc.data_out, ifc.dp_out);
        end
        data_v[15:0] = 16'hBEEF;
        #1;
        n_tests++;
        if (ifc.data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL live_lag: data=%h, required 1234", ifc.data_out);
        end
        step();
        n_tests++;
        if (ifc.data_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL live_update: data=%h, required beef", ifc.data_out);
        end
    endtask

    task automatic test_preempt();
        int own3, exp_own;
        do_reset();
        req_v = 4'b1000;
        repeat (3) step();
        own3  = 3;
        req_v = 4'b1001;
        for (int c = 0; c < 30 && ifc.grant !== 4'b0001; c++) begin
            step();
            if (ifc.grant === 4'b1000) own3++;
        end
`ifdef SSD_ARB_PREEMPT_EN
        exp_own = 3;
`else
        exp_own = HOLD;
`endif
        n_tests++;
        if (ifc.grant !== 4'b0001 || own3 != exp_own) begin
            n_fail++;
            $display("FAIL req0_wait: grant=%b owner3_cycles=%0d, required 0001 %0d",
                     ifc.grant, own3, exp_own);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_v = 4'b0010;
        repeat (2) step();
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (ifc.grant !== 4'b0 || ifc.disp_en !== 1'b0 || ifc.data_out !== 16'h0 ||
            ifc.owner !== 2'd3) begin
            n_fail++;
            $display("FAIL async_reset: grant=%b en=%b data=%h owner=%0d, required 0000 0 0000 3",
                     ifc.grant, ifc.disp_en, ifc.data_out, ifc.owner);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 9) == 0) req_v = 4'($urandom);
            data_v = {$urandom, $urandom};
            dp_v   = 16'($urandom);
            step();
            n_tests++;
            if (ifc.grant !== m_grant || ifc.owner !== 2'(m_owner) || ifc.data_out !== m_data ||
                ifc.dp_out !== m_dp || ifc.disp_en !== m_en) begin
                n_fail++;
                $display("FAIL random@%0d: grant=%b owner=%0d data=%h dp=%h en=%b, required %b %0d %h %h %b",
                         c, ifc.grant, ifc.owner, ifc.data_out, ifc.dp_out, ifc.disp_en,
                         m_grant, m_owner, m_data, m_dp, m_en);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        req_v  = 4'b0;
        data_v = 64'h0;
        dp_v   = 16'h0;
        test_reset();
        test_idle_pick();
        test_handover();
        test_drop();
        test_live_data();
        test_preempt();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
